// File: rtl/lottery_pkg.sv
// Shared types and constants for the weighted lottery arbiter: FSM states,
// requester count, Galois LFSR tap mask and a one-hot helper.
package lottery_pkg;

  typedef enum logic [1:0] {IDLE, DRAW, GRANT} state_e;

  localparam int NUM_REQ = 4;

  // x^16 + x^14 + x^13 + x^11 + 1 for a right-shifting Galois LFSR
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  function automatic logic [NUM_REQ-1:0] onehot(input logic [1:0] idx);
    logic [NUM_REQ-1:0] vec;
    vec = '0;
    vec[idx] = 1'b1;
    return vec;
  endfunction

endpackage

// File: rtl/lottery_lfsr.sv
// 16-bit Galois LFSR with seed load (priority), zero-seed guard and
// enable-gated advance; the seed is also loaded under synchronous reset.
module lottery_lfsr
  import lottery_pkg::*;
#(
  parameter int LFSR_WIDTH = 16
) (
  input  logic                  clk_i,
  input  logic                  srst_i,
  input  logic                  en_i,
  input  logic                  seed_load_i,
  input  logic [LFSR_WIDTH-1:0] seed_i,
  output logic [LFSR_WIDTH-1:0] lfsr_o
);

  logic [LFSR_WIDTH-1:0] lfsr_q, lfsr_d, seed_nz;

  // An all-zero state would lock the LFSR, so a zero seed becomes 1.
  assign seed_nz = (seed_i == '0) ? LFSR_WIDTH'(1) : seed_i;

  always_comb begin
    lfsr_d = lfsr_q;
    if (seed_load_i) begin
      lfsr_d = seed_nz;
    end else if (en_i) begin
      lfsr_d = (lfsr_q >> 1) ^ (lfsr_q[0] ? LFSR_TAPS : '0);
    end
  end

  always_ff @(posedge clk_i) begin
    if (srst_i) lfsr_q <= seed_nz;
    else        lfsr_q <= lfsr_d;
  end

  assign lfsr_o = lfsr_q;

endmodule

// File: rtl/weighted_lottery_arbiter.sv
// Four-way weighted lottery arbiter: IDLE -> DRAW -> GRANT with hold limit and
// release handshake. Define LOTTERY_STARVATION_GUARD_EN to add per-requester aging.
module weighted_lottery_arbiter
  import lottery_pkg::*;
#(
  parameter int WIDTH      = 10,
  parameter int LFSR_WIDTH = 16,
  parameter int MAX_HOLD   = 15,
  parameter int AGE_LIMIT  = 8
) (
  input  logic                  in_clock,
  input  logic                  in_reset,
  input  logic                  in_enable,
  input  logic [LFSR_WIDTH-1:0] in_seed,
  input  logic                  in_seed_load,
  input  logic [NUM_REQ-1:0]    in_req,
  input  logic [WIDTH:0]        in_weight0,
  input  logic [WIDTH:0]        in_weight1,
  input  logic [WIDTH:0]        in_weight2,
  input  logic [WIDTH:0]        in_weight3,
  input  logic                  in_release,
  output logic [NUM_REQ-1:0]    out_grant,
  output logic [1:0]            out_segment_number,
  output logic                  out_busy,
  output logic                  out_timeout
);

  localparam int TW = WIDTH + 3;
  localparam int PW = LFSR_WIDTH + TW;
  localparam int HW = $clog2(MAX_HOLD + 1);

  if (LFSR_WIDTH != 16 || MAX_HOLD < 1 || AGE_LIMIT < 1) begin : g_cfg_check
    $error("weighted_lottery_arbiter: unsupported parameter set");
  end

  state_e               state_q, state_d;
  logic [NUM_REQ-1:0]   elig, elig_q, elig_d, grant_q, grant_d;
  logic [WIDTH:0]       weight_in [NUM_REQ];
  logic [WIDTH:0]       weight_q  [NUM_REQ];
  logic [WIDTH:0]       weight_d  [NUM_REQ];
  logic [1:0]           seg_q, seg_d, win;
  logic [HW-1:0]        hold_q, hold_d;
  logic                 timeout_q, timeout_d;
  logic [LFSR_WIDTH-1:0] lfsr;
  logic [TW-1:0]        cum [NUM_REQ];
  logic [TW-1:0]        pick;

  assign weight_in[0] = in_weight0;
  assign weight_in[1] = in_weight1;
  assign weight_in[2] = in_weight2;
  assign weight_in[3] = in_weight3;

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_elig
    assign elig[gi] = in_req[gi] && (weight_in[gi] != '0);
  end

  lottery_lfsr #(.LFSR_WIDTH(LFSR_WIDTH)) u_lfsr (
    .clk_i       (in_clock),
    .srst_i      (in_reset),
    .en_i        (in_enable),
    .seed_load_i (in_seed_load),
    .seed_i      (in_seed),
    .lfsr_o      (lfsr)
  );

`ifdef LOTTERY_STARVATION_GUARD_EN
  localparam int MW = $clog2(AGE_LIMIT + 1);
  logic [MW-1:0]      miss_q [NUM_REQ];
  logic [MW-1:0]      miss_d [NUM_REQ];
  logic [NUM_REQ-1:0] starved;

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_starved
    assign starved[gi] = elig_q[gi] && (miss_q[gi] >= MW'(AGE_LIMIT));
  end

  // Miss counters saturate at AGE_LIMIT; dropping the request forgives history.
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      miss_d[i] = miss_q[i];
      if (!in_req[i]) begin
        miss_d[i] = '0;
      end else if (state_q == DRAW) begin
        if (win == 2'(i))                                     miss_d[i] = '0;
        else if (elig_q[i] && miss_q[i] != MW'(AGE_LIMIT))    miss_d[i] = miss_q[i] + 1'b1;
      end
    end
  end

  always_ff @(posedge in_clock) begin
    for (int i = 0; i < NUM_REQ; i++) begin
      if (in_reset) miss_q[i] <= '0;
      else          miss_q[i] <= miss_d[i];
    end
  end
`endif

  // Draw uses the weights latched on leaving IDLE, so later weight changes wait.
  always_comb begin
    logic [TW-1:0] acc;
    logic          found;
    acc = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (elig_q[i]) acc = acc + TW'(weight_q[i]);
      cum[i] = acc;
    end
    pick  = TW'((PW'(lfsr) * PW'(cum[NUM_REQ-1])) >> LFSR_WIDTH);
    win   = '0;
    found = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found && elig_q[i] && pick < cum[i]) begin
        win   = 2'(i);
        found = 1'b1;
      end
    end
`ifdef LOTTERY_STARVATION_GUARD_EN
    found = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found && starved[i]) begin
        win   = 2'(i);
        found = 1'b1;
      end
    end
`endif
  end

  always_comb begin
    state_d   = state_q;
    elig_d    = elig_q;
    weight_d  = weight_q;
    grant_d   = grant_q;
    seg_d     = seg_q;
    hold_d    = hold_q;
    timeout_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_enable && |elig) begin
          state_d  = DRAW;
          elig_d   = elig;
          weight_d = weight_in;
        end
      end
      DRAW: begin
        grant_d = onehot(win);
        seg_d   = win;
        hold_d  = '0;
        state_d = GRANT;
      end
      GRANT: begin
        hold_d = hold_q + 1'b1;
        // Explicit or implicit release outranks a coincident timeout.
        if (in_release || !in_req[seg_q]) begin
          state_d = IDLE;
          grant_d = '0;
        end else if (hold_q == HW'(MAX_HOLD - 1)) begin
          state_d   = IDLE;
          grant_d   = '0;
          timeout_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge in_clock) begin
    if (in_reset) begin
      state_q   <= IDLE;
      elig_q    <= '0;
      grant_q   <= '0;
      seg_q     <= '0;
      hold_q    <= '0;
      timeout_q <= 1'b0;
      for (int i = 0; i < NUM_REQ; i++) weight_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      elig_q    <= elig_d;
      grant_q   <= grant_d;
      seg_q     <= seg_d;
      hold_q    <= hold_d;
      timeout_q <= timeout_d;
      weight_q  <= weight_d;
    end
  end

  assign out_grant          = grant_q;
  assign out_segment_number = seg_q;
  assign out_busy           = (state_q != IDLE);
  assign out_timeout        = timeout_q;

endmodule

// File: tb/tb_weighted_lottery_arbiter.sv
// Directed bench for weighted_lottery_arbiter: seeded single-draw table plus
// hand-written sequences for hold, timeout, reset and distribution corners.
module tb_weighted_lottery_arbiter;

  localparam int WIDTH = 10;
  localparam int LW    = 16;

  logic          in_clock = 1'b0;
  logic          in_reset, in_enable, in_seed_load, in_release;
  logic [LW-1:0] in_seed;
  logic [3:0]    in_req;
  logic [WIDTH:0] in_weight0, in_weight1, in_weight2, in_weight3;
  logic [3:0]    out_grant;
  logic [1:0]    out_segment_number;
  logic          out_busy, out_timeout;

  int applied     = 0;
  int miscompares = 0;
  int seq_buf [20];
  int seq_a   [20];
  int got;

  always #5 in_clock = ~in_clock;

  weighted_lottery_arbiter #(.WIDTH(WIDTH), .LFSR_WIDTH(LW), .MAX_HOLD(15), .AGE_LIMIT(8)) dut (
    .in_clock           (in_clock),
    .in_reset           (in_reset),
    .in_enable          (in_enable),
    .in_seed            (in_seed),
    .in_seed_load       (in_seed_load),
    .in_req             (in_req),
    .in_weight0         (in_weight0),
    .in_weight1         (in_weight1),
    .in_weight2         (in_weight2),
    .in_weight3         (in_weight3),
    .in_release         (in_release),
    .out_grant          (out_grant),
    .out_segment_number (out_segment_number),
    .out_busy           (out_busy),
    .out_timeout        (out_timeout)
  );

  typedef struct {
    logic [15:0] seed;
    logic [3:0]  req;
    logic [10:0] w0, w1, w2, w3;
    logic [3:0]  exp_grant;
    logic [1:0]  exp_seg;
  } vec_t;

  localparam int NV = 16;
  vec_t vecs [NV];

  task automatic check(input string name, input int act, input int exp);
    applied++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic set_w(input int a, input int b, input int c, input int d);
    in_weight0 = 11'(a);
    in_weight1 = 11'(b);
    in_weight2 = 11'(c);
    in_weight3 = 11'(d);
  endtask

  // Reset with a seed, then collect 20 grant indices with release held high.
  task automatic collect(input logic [15:0] seed);
    in_reset = 1'b1; in_seed = seed; in_enable = 1'b1; in_seed_load = 1'b0;
    in_req = 4'b1111; set_w(2, 4, 2, 0); in_release = 1'b1;
    @(negedge in_clock);
    in_reset = 1'b0;
    got = 0;
    for (int c = 0; c < 200 && got < 20; c++) begin
      @(negedge in_clock);
      if (out_grant != 4'b0000) begin
        seq_buf[got] = int'(out_segment_number);
        got++;
      end
    end
  endtask

  initial begin
    int cnt, early, bad, runlen, maxrun;
    int counts [4];

    // Draw pick = (seed * total) >> 16 when the seed is loaded on the IDLE->DRAW edge.
    vecs[0]  = '{16'h0000, 4'b1111,    2,    4,    2,    0, 4'b0001, 2'd0};
    vecs[1]  = '{16'h3FFF, 4'b1111,    2,    4,    2,    0, 4'b0001, 2'd0};
    vecs[2]  = '{16'h4000, 4'b1111,    2,    4,    2,    0, 4'b0010, 2'd1};
    vecs[3]  = '{16'hBFFF, 4'b1111,    2,    4,    2,    0, 4'b0010, 2'd1};
    vecs[4]  = '{16'hC000, 4'b1111,    2,    4,    2,    0, 4'b0100, 2'd2};
    vecs[5]  = '{16'hFFFF, 4'b1111,    2,    4,    2,    0, 4'b0100, 2'd2};
    vecs[6]  = '{16'h5555, 4'b0111,    1,    1,    1,    0, 4'b0001, 2'd0};
    vecs[7]  = '{16'h5556, 4'b0111,    1,    1,    1,    0, 4'b0010, 2'd1};
    vecs[8]  = '{16'hAAAA, 4'b0111,    1,    1,    1,    0, 4'b0010, 2'd1};
    vecs[9]  = '{16'hAAAB, 4'b0111,    1,    1,    1,    0, 4'b0100, 2'd2};
    vecs[10] = '{16'h8000, 4'b1010,    3,    5,    7,    9, 4'b1000, 2'd3};
    vecs[11] = '{16'h5000, 4'b1010,    3,    5,    7,    9, 4'b0010, 2'd1};
    vecs[12] = '{16'h1234, 4'b1111,    0,    0,    0,    6, 4'b1000, 2'd3};
    vecs[13] = '{16'h7FFF, 4'b1001, 2047,    0,    0, 2047, 4'b0001, 2'd0};
    vecs[14] = '{16'h8000, 4'b1001, 2047,    0,    0, 2047, 4'b1000, 2'd3};
    vecs[15] = '{16'hFFFF, 4'b1111, 2047, 2047, 2047, 2047, 4'b1000, 2'd3};

    in_reset = 1'b1; in_enable = 1'b0; in_seed = 16'hACE1; in_seed_load = 1'b0;
    in_req = 4'b0000; in_release = 1'b0; set_w(0, 0, 0, 0);
    repeat (2) @(negedge in_clock);
    check("reset_grant",   int'(out_grant), 0);
    check("reset_seg",     int'(out_segment_number), 0);
    check("reset_busy",    int'(out_busy), 0);
    check("reset_timeout", int'(out_timeout), 0);
    in_reset = 1'b0; in_enable = 1'b1;
    @(negedge in_clock);

    for (int v = 0; v < NV; v++) begin
      in_req = vecs[v].req; in_seed = vecs[v].seed; in_seed_load = 1'b1;
      set_w(int'(vecs[v].w0), int'(vecs[v].w1), int'(vecs[v].w2), int'(vecs[v].w3));
      @(negedge in_clock);
      in_seed_load = 1'b0;
      check($sformatf("v%0d_draw_busy", v), int'(out_busy), 1);
      check($sformatf("v%0d_draw_grant", v), int'(out_grant), 0);
      @(negedge in_clock);
      check($sformatf("v%0d_grant", v), int'(out_grant), int'(vecs[v].exp_grant));
      check($sformatf("v%0d_seg", v), int'(out_segment_number), int'(vecs[v].exp_seg));
      in_release = 1'b1;
      @(negedge in_clock);
      in_release = 1'b0; in_req = 4'b0000;
      check($sformatf("v%0d_released", v), int'(out_grant), 0);
    end

    // Single requester: grant two edges after request rises, repeatedly.
    set_w(0, 5, 0, 0);
    in_req = 4'b0010;
    @(negedge in_clock);
    check("lat_edge1_grant", int'(out_grant), 0);
    @(negedge in_clock);
    check("lat_edge2_grant", int'(out_grant), 2);
    check("lat_edge2_seg",   int'(out_segment_number), 1);
    for (int k = 0; k < 4; k++) begin
      in_release = 1'b1;
      @(negedge in_clock);
      in_release = 1'b0;
      check("repeat_idle_gap", int'(out_grant), 0);
      repeat (2) @(negedge in_clock);
      check("repeat_grant", int'(out_grant), 2);
    end
    in_release = 1'b1;
    @(negedge in_clock);
    in_release = 1'b0; in_req = 4'b0000;
    @(negedge in_clock);

    // Never released: held 15 cycles, then a single-cycle timeout pulse.
    in_req = 4'b0010;
    repeat (2) @(negedge in_clock);
    cnt = 0; early = 0;
    for (int c = 0; c < 40; c++) begin
      if (out_grant == 4'b0000) break;
      cnt++;
      if (out_timeout) early++;
      @(negedge in_clock);
    end
    check("hold_cycles", cnt, 15);
    check("timeout_early", early, 0);
    check("timeout_pulse", int'(out_timeout), 1);
    in_req = 4'b0000;
    @(negedge in_clock);
    check("timeout_one_cycle", int'(out_timeout), 0);

    // Release on the 15th grant cycle wins over the timeout.
    in_req = 4'b0010;
    repeat (2) @(negedge in_clock);
    repeat (14) @(negedge in_clock);
    check("rel15_still_held", int'(out_grant), 2);
    in_release = 1'b1;
    @(negedge in_clock);
    check("rel15_grant", int'(out_grant), 0);
    check("rel15_no_timeout", int'(out_timeout), 0);
    in_release = 1'b0; in_req = 4'b0000;
    @(negedge in_clock);

    // Dropping the winner's request releases implicitly.
    in_req = 4'b0010;
    repeat (2) @(negedge in_clock);
    in_req = 4'b0000;
    @(negedge in_clock);
    check("implicit_rel_grant", int'(out_grant), 0);
    check("implicit_rel_timeout", int'(out_timeout), 0);

    // Weight cleared mid-grant: current grant stays, next draw sees weight 0.
    in_req = 4'b0010;
    repeat (2) @(negedge in_clock);
    in_weight1 = 11'd0;
    @(negedge in_clock);
    check("wchg_grant_kept", int'(out_grant), 2);
    in_release = 1'b1;
    @(negedge in_clock);
    in_release = 1'b0;
    bad = 0;
    repeat (5) begin
      @(negedge in_clock);
      if (out_busy || out_grant != 4'b0000) bad++;
    end
    check("wchg_no_redraw", bad, 0);
    in_req = 4'b0000; in_weight1 = 11'd5;
    @(negedge in_clock);

    // Enable dropped during DRAW: the grant still completes.
    in_req = 4'b0010;
    @(negedge in_clock);
    in_enable = 1'b0;
    @(negedge in_clock);
    check("en_low_draw_grant", int'(out_grant), 2);
    in_release = 1'b1;
    @(negedge in_clock);
    in_release = 1'b0; in_req = 4'b0000;

    // No draw with enable low, nor with every weight zero.
    in_req = 4'b1111; set_w(2, 4, 2, 0);
    bad = 0;
    repeat (100) begin
      @(negedge in_clock);
      if (out_busy || out_grant != 4'b0000) bad++;
    end
    check("enable_low_idle", bad, 0);
    in_enable = 1'b1; set_w(0, 0, 0, 0);
    bad = 0;
    repeat (100) begin
      @(negedge in_clock);
      if (out_busy || out_grant != 4'b0000) bad++;
    end
    check("zero_weights_idle", bad, 0);

    // Reset in the middle of a grant.
    in_req = 4'b0010; set_w(0, 5, 0, 0);
    repeat (2) @(negedge in_clock);
    check("pre_reset_grant", int'(out_grant), 2);
    in_reset = 1'b1;
    @(negedge in_clock);
    check("midreset_grant", int'(out_grant), 0);
    check("midreset_seg",   int'(out_segment_number), 0);
    check("midreset_busy",  int'(out_busy), 0);
    in_reset = 1'b0; in_req = 4'b0000;

    // Seed 0 maps to seed 1, so both runs must match draw for draw.
    collect(16'h0001);
    check("seq_a_len", got, 20);
    for (int i = 0; i < 20; i++) seq_a[i] = seq_buf[i];
    collect(16'h0000);
    check("seq_b_len", got, 20);
    bad = 0;
    for (int i = 0; i < 20; i++) if (seq_a[i] != seq_buf[i]) bad++;
    check("seed0_vs_seed1", bad, 0);

    // Distribution with weights 2/4/2/0: 25%/50%/25%/0 within +-3%.
    collect(16'hACE1);
    for (int i = 0; i < 4; i++) counts[i] = 0;
    cnt = 0; bad = 0;
    for (int c = 0; c < 20000 && cnt < 4000; c++) begin
      @(negedge in_clock);
      if (out_grant != 4'b0000) begin
        if (out_grant != (4'b0001 << out_segment_number)) bad++;
        counts[out_segment_number]++;
        cnt++;
      end
    end
    check("dist_grants", cnt, 4000);
    check("dist_onehot", bad, 0);
    check("dist_req3", counts[3], 0);
    check("dist_req0_in_band", int'(counts[0] >= 880  && counts[0] <= 1120), 1);
    check("dist_req1_in_band", int'(counts[1] >= 1880 && counts[1] <= 2120), 1);
    check("dist_req2_in_band", int'(counts[2] >= 880  && counts[2] <= 1120), 1);

`ifdef LOTTERY_STARVATION_GUARD_EN
    // Weights 1/1000: aging forces req0 to win within every 9 draws.
    in_req = 4'b0011; set_w(1, 1000, 0, 0);
    cnt = 0; runlen = 0; maxrun = 0;
    for (int c = 0; c < 5000 && cnt < 300; c++) begin
      @(negedge in_clock);
      if (out_grant != 4'b0000) begin
        cnt++;
        if (out_segment_number == 2'd0) runlen = 0;
        else runlen++;
        if (runlen > maxrun) maxrun = runlen;
      end
    end
    check("guard_grants", cnt, 300);
    check("guard_max_losses_le8", int'(maxrun <= 8), 1);
`else
    runlen = 0; maxrun = 0;
`endif

    in_release = 1'b0; in_req = 4'b0000;
    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end

endmodule

// File: doc/weighted_lottery_arbiter.md
Name: weighted_lottery_arbiter

Overview:
- Shares one memory-controller resource (command slot / segment port) between 4 requesters.
- Each grant goes by weighted random draw: P(win) = weight_i / sum of eligible weights.
- Internal LFSR supplies randomness; the draw engine is sequenced by a small FSM with grant hold and release handshake.
- Sits between traffic sources and the command scheduler; drives out_segment_number like the existing random-choice datapath.

Parameters:
- WIDTH, 10, weight MSB index; each weight is [WIDTH:0].
- LFSR_WIDTH, 16, LFSR/seed width; only 16 is supported (fixed taps).
- MAX_HOLD, 15, max cycles a grant is held before forced release (>=1).
- AGE_LIMIT, 8, consecutive lost draws before forced win (optional feature only).

Ports:
- in_clock  in  1  sole clock, rising edge.
- in_reset  in  1  synchronous, active-high reset.
- in_enable  in  1  permits new draws; an in-progress grant continues when low.
- in_seed  in  LFSR_WIDTH  LFSR seed, loaded at reset or on in_seed_load.
- in_seed_load  in  1  load in_seed into the LFSR this edge.
- in_req  in  4  request per requester, level.
- in_weight0..in_weight3  in  WIDTH+1 each  per-requester weight; 0 means never granted.
- in_release  in  1  granted requester is finished; sampled only in GRANT.
- out_grant  out  4  one-hot grant, registered.
- out_segment_number  out  2  index of the current/last winner.
- out_busy  out  1  high in DRAW or GRANT.
- out_timeout  out  1  one-cycle pulse on forced release.

Behaviour:
- Reset (synchronous, active-high):
  - state=IDLE; out_grant=0, out_segment_number=0, out_busy=0, out_timeout=0, hold counter=0.
  - LFSR loads in_seed; a seed of 0 is replaced by 1.
- LFSR: Galois, polynomial x^16+x^14+x^13+x^11+1. Advances every cycle in_enable=1. in_seed_load has priority over advance, with the same zero-to-1 rule.
- Eligible mask: elig[i] = in_req[i] && (weight_i != 0).
- Total: sum of eligible weights, WIDTH+3 bits, no overflow possible.
- FSM:
  - IDLE: if in_enable && |elig, go to DRAW and latch elig and weights; otherwise stay.
  - DRAW: pick = (lfsr * total) >> LFSR_WIDTH, so 0 <= pick < total. Winner = lowest i with pick < cumulative eligible weight up to i. Set out_grant (one-hot), out_segment_number=i, clear hold counter, go to GRANT.
  - GRANT: hold counter increments each cycle. Exit to IDLE with out_grant=0 on any of:
    - in_release=1;
    - in_req[winner] deasserted (implicit release);
    - counter reaching MAX_HOLD, which also pulses out_timeout for 1 cycle.
- Latency: request seen at edge N (IDLE) gives out_grant valid after edge N+1. Minimum one IDLE cycle between grants.
- Simultaneous release and timeout: treated as a release; no out_timeout pulse.
- Weight change during GRANT: no effect on the current grant; the next draw uses new values.
- in_enable low in IDLE: no draw. Low during DRAW/GRANT: the sequence completes.
- Reset mid-grant: all outputs are at reset values after that edge.
- Identical seed plus identical stimulus gives an identical grant sequence (deterministic).

Optional Feature:
- Macro: LOTTERY_STARVATION_GUARD_EN.
- Defined:
  - Each requester has a saturating miss counter. It increments when the requester is eligible in a draw and loses, and clears on a win or when not requesting.
  - If any counter >= AGE_LIMIT at DRAW, the lowest-index such requester wins outright and the LFSR result is ignored.
- Undefined: counters absent; pure weighted draw.

Decomposition:
- Package lottery_pkg:
  - state enum {IDLE, DRAW, GRANT};
  - NUM_REQ=4;
  - LFSR tap mask constant;
  - function onehot(idx).
- Sub-module lottery_lfsr: seed load, zero guard, enable-gated advance.
- FSM, draw arithmetic and hold logic stay in the top module.

Test Plan:
1. Weights 2,4,2,0, in_req=4'b1111, in_release on the first grant cycle, 4000 grants → req3 never granted; req0/1/2 shares 25%/50%/25% ±3%.
2. Only in_req[1] high, weight1=5 → every grant is 4'b0010, out_segment_number=1, grant appears 2 edges after req rises.
3. One requester, never releases, MAX_HOLD=15 → grant drops after 15 GRANT cycles, out_timeout high exactly 1 cycle; in_release on cycle 15 → no timeout.
4. All weights 0 with in_req=4'b1111, or in_enable=0 → out_grant and out_busy stay 0 for 100 cycles.
5. Reset asserted mid-GRANT → out_grant=0 next edge. Rerun with seed 16'h0001 and with seed 0 → identical grant sequences.
6. With LOTTERY_STARVATION_GUARD_EN, weights 1,1000,0,0, AGE_LIMIT=8 → req0 wins at least once in every 9 consecutive draws.
